// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor: pulses pll_rst, waits for a stable lock, then releases sys_rst.
// Define PLL_SUP_RETRY_LIMIT_EN to stop in FAIL after MAX_RETRIES consecutive lock timeouts.
module pll_lock_supervisor #(
    parameter int RST_PULSE_CYCLES   = 16,
    parameter int LOCK_TIMEOUT       = 50000,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES        = 4,
    parameter int CNT_W              = 16
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [7:0] loss_count
);

    if (RST_PULSE_CYCLES < 1 || LOCK_TIMEOUT < 1 || LOCK_STABLE_CYCLES < 1 || MAX_RETRIES < 1) begin : g_param_check
        $error("pll_lock_supervisor: cycle parameters must be >= 1");
    end

    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);

`ifdef PLL_SUP_RETRY_LIMIT_EN
    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRIES - 1);

    typedef enum logic [2:0] {RESET_PLL, WAIT_LOCK, STABILIZE, RUN, FAIL} state_t;

    logic [RETRY_W-1:0] retry_q, retry_d;
`else
    typedef enum logic [1:0] {RESET_PLL, WAIT_LOCK, STABILIZE, RUN} state_t;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       loss_d;
    logic             sync0, locked_s;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        loss_d  = loss_count;
`ifdef PLL_SUP_RETRY_LIMIT_EN
        retry_d = retry_q;
`endif
        case (state_q)
            RESET_PLL: begin
                if (cnt_q == PULSE_LAST) begin
                    cnt_d   = '0;
                    state_d = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                // lock is checked first so it wins over a simultaneous timeout
                if (locked_s) begin
                    cnt_d   = '0;
                    state_d = STABILIZE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d   = '0;
                    state_d = RESET_PLL;
`ifdef PLL_SUP_RETRY_LIMIT_EN
                    retry_d = retry_q + 1'b1;
                    if (retry_q == RETRY_LAST)
                        state_d = FAIL;
`endif
                end
            end
            STABILIZE: begin
                if (!locked_s) begin
                    cnt_d   = '0;
                    state_d = WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef PLL_SUP_RETRY_LIMIT_EN
                    retry_d = '0;
`endif
                end
            end
            RUN: begin
                cnt_d = cnt_q;
                if (!locked_s) begin
                    cnt_d   = '0;
                    state_d = RESET_PLL;
                    if (loss_count != 8'hFF)
                        loss_d = loss_count + 8'd1;
                end
            end
`ifdef PLL_SUP_RETRY_LIMIT_EN
            FAIL: cnt_d = cnt_q;
`endif
            default: begin
                cnt_d   = '0;
                state_d = RESET_PLL;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the transition edge.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q    <= RESET_PLL;
            cnt_q      <= '0;
            sync0      <= 1'b0;
            locked_s   <= 1'b0;
            pll_rst    <= 1'b1;
            sys_rst    <= 1'b1;
            ready      <= 1'b0;
            loss_count <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sync0      <= pll_locked;
            locked_s   <= sync0;
            sys_rst    <= (state_d != RUN);
            ready      <= (state_d == RUN);
            loss_count <= loss_d;
`ifdef PLL_SUP_RETRY_LIMIT_EN
            pll_rst    <= (state_d == RESET_PLL) || (state_d == FAIL);
`else
            pll_rst    <= (state_d == RESET_PLL);
`endif
        end
    end

`ifdef PLL_SUP_RETRY_LIMIT_EN
    always_ff @(posedge refclk) begin
        if (rst) begin
            retry_q <= '0;
            fail    <= 1'b0;
        end else begin
            retry_q <= retry_d;
            fail    <= (state_d == FAIL);
        end
    end
`else
    assign fail = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed + randomized bench for pll_lock_supervisor, checked every cycle against a
// phase/elapsed-time reference model.
module tb_pll_lock_supervisor;

    localparam int RP = 4;
    localparam int TO = 100;
    localparam int ST = 8;
    localparam int MR = 3;
`ifdef PLL_SUP_RETRY_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    localparam int PH_RST = 0, PH_WAIT = 1, PH_STAB = 2, PH_RUN = 3, PH_FAIL = 4;

    logic       refclk = 1'b0;
    logic       rst, pll_locked;
    logic       pll_rst, sys_rst, ready, fail;
    logic [7:0] loss_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // reference model: phase, edges spent in it, timeouts in a row, losses, 2-deep lock history
    int m_ph, m_age, m_tries, m_loss;
    bit m_s0, m_s1;

    pll_lock_supervisor #(
        .RST_PULSE_CYCLES(RP), .LOCK_TIMEOUT(TO), .LOCK_STABLE_CYCLES(ST),
        .MAX_RETRIES(MR), .CNT_W(16)
    ) dut (
        .refclk(refclk), .rst(rst), .pll_locked(pll_locked),
        .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready), .fail(fail),
        .loss_count(loss_count)
    );

    always #10 refclk = ~refclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic enter(input int ph);
        m_ph  = ph;
        m_age = 0;
    endtask

    task automatic model_edge(input bit r, input bit l);
        bit lk;
        lk   = m_s1;
        m_s1 = m_s0;
        m_s0 = l;
        if (r) begin
            enter(PH_RST);
            m_tries = 0; m_loss = 0; m_s0 = 0; m_s1 = 0;
            return;
        end
        m_age++;
        case (m_ph)
            PH_RST:  if (m_age == RP) enter(PH_WAIT);
            PH_WAIT: begin
                if (lk) enter(PH_STAB);
                else if (m_age == TO) begin
                    m_tries++;
                    if (LIMIT && m_tries == MR) enter(PH_FAIL);
                    else enter(PH_RST);
                end
            end
            PH_STAB: begin
                if (!lk) enter(PH_WAIT);
                else if (m_age == ST) begin enter(PH_RUN); m_tries = 0; end
            end
            PH_RUN: if (!lk) begin
                enter(PH_RST);
                if (m_loss < 255) m_loss++;
            end
            default: ;
        endcase
    endtask

    task automatic tick(input bit r, input bit l);
        rst = r;
        pll_locked = l;
        @(posedge refclk);
        model_edge(r, l);
        cyc++;
        @(negedge refclk);
        chk("pll_rst", 32'(pll_rst), 32'(m_ph == PH_RST || m_ph == PH_FAIL));
        chk("sys_rst", 32'(sys_rst), 32'(m_ph != PH_RUN));
        chk("ready", 32'(ready), 32'(m_ph == PH_RUN));
        chk("fail", 32'(fail), 32'(m_ph == PH_FAIL));
        chk("loss_count", 32'(loss_count), 32'(m_loss));
    endtask

    initial begin
        int n;
        int hi;
        bit lvl;

        m_ph = PH_RST; m_age = 0; m_tries = 0; m_loss = 0; m_s0 = 0; m_s1 = 0;

        // 1: reset, pulse width, lock-to-ready latency
        repeat (3) tick(1, 0);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            tick(0, 0);
            if (pll_rst) hi++;
        end
        chk("t1_pulse_width", 32'(hi + 1), 32'(RP));
        n = 0;
        do begin tick(0, 1); n++; end while (!ready && n < 50);
        chk("t1_lock_to_ready", 32'(n - 1), 32'(ST + 2));
        chk("t1_sys_rst", 32'(sys_rst), 32'd0);
        chk("t1_loss", 32'(loss_count), 32'd0);

        // 2: lock loss in RUN
        tick(0, 0); chk("t2_sysrst_n", 32'(sys_rst), 32'd0);
        tick(0, 0); chk("t2_sysrst_n1", 32'(sys_rst), 32'd0);
        tick(0, 0); chk("t2_sysrst_n2", 32'(sys_rst), 32'd1);
        chk("t2_ready_n2", 32'(ready), 32'd0);
        chk("t2_loss", 32'(loss_count), 32'd1);
        repeat (20) tick(0, 1);
        chk("t2_relock", 32'(ready), 32'd1);

        // 3: one-cycle glitch during STABILIZE at count 5
        tick(1, 1);
        n = 0;
        while (!(m_ph == PH_STAB && m_age == 5) && n < 50) begin tick(0, 1); n++; end
        chk("t3_reach_stab5", 32'(m_ph == PH_STAB && m_age == 5), 32'd1);
        tick(0, 0);
        n = 1;
        while (!ready && n < 50) begin tick(0, 1); n++; end
        chk("t3_glitch_to_ready", 32'(n), 32'd12);
        chk("t3_loss", 32'(loss_count), 32'd0);

        // 4: no lock at all
        tick(1, 0);
        repeat (400) tick(0, 0);
        chk("t4_fail", 32'(fail), 32'(LIMIT));
        if (LIMIT) chk("t4_pll_rst_held", 32'(pll_rst), 32'd1);
        tick(1, 0);
        chk("t4_fail_cleared", 32'(fail), 32'd0);
        repeat (10) tick(0, 0);

        // 5: saturate loss_count
        tick(1, 1);
        for (int k = 0; k < 260; k++) begin
            repeat (20) tick(0, 1);
            tick(0, 0);
        end
        repeat (5) tick(0, 1);
        chk("t5_saturate", 32'(loss_count), 32'd255);

        // 6: reset mid WAIT_LOCK with lock present
        tick(1, 0);
        repeat (6) tick(0, 0);
        tick(1, 1);
        chk("t6_pll_rst", 32'(pll_rst), 32'd1);
        chk("t6_sys_rst", 32'(sys_rst), 32'd1);
        chk("t6_ready", 32'(ready), 32'd0);
        hi = 1;
        for (int i = 0; i < 8; i++) begin
            tick(0, 1);
            if (pll_rst) hi++;
        end
        chk("t6_pulse_width", 32'(hi), 32'(RP));

        // randomized segments of lock level, occasional reset
        lvl = 1'b1;
        for (int s = 0; s < 60; s++) begin
            int len;
            lvl = ($urandom_range(0, 3) != 0);
            len = (s % 4 == 0) ? $urandom_range(1, 4) : $urandom_range(1, 150);
            if ($urandom_range(0, 9) == 0) tick(1, lvl);
            repeat (len) tick(0, lvl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
